// File: rtl/rf_hazard_ctrl_if.sv
// RF-stage hazard controller signal bundle.
// Decode/EX/FIFO status in, pipeline strobes and status out.
interface rf_hazard_ctrl_if #(
  parameter int unsigned CNTW = 16
);
  logic            dec_valid;
  logic [4:0]      dec_rs1;
  logic [4:0]      dec_rs2;
  logic            dec_use_rs1;
  logic            dec_use_rs2;
  logic            dec_flag512;
  logic            dec_nwload;
  logic [4:0]      ex_rd;
  logic            ex_load;
  logic            ex_flag512;
  logic            branch_taken;
  logic            ex_stall;
  logic            fifo_empty;
  logic            stall_id;
  logic            stall_rf;
  logic            clear_rf;
  logic            fiforeaden;
  logic            nw_timeout;
  logic [CNTW-1:0] wait_cnt;
  logic [CNTW-1:0] drop_cnt;

  modport master (
    output dec_valid, dec_rs1, dec_rs2,
    output dec_use_rs1, dec_use_rs2,
    output dec_flag512, dec_nwload,
    output ex_rd, ex_load, ex_flag512,
    output branch_taken, ex_stall,
    output fifo_empty,
    input  stall_id, stall_rf, clear_rf,
    input  fiforeaden, nw_timeout,
    input  wait_cnt, drop_cnt
  );

  modport slave (
    input  dec_valid, dec_rs1, dec_rs2,
    input  dec_use_rs1, dec_use_rs2,
    input  dec_flag512, dec_nwload,
    input  ex_rd, ex_load, ex_flag512,
    input  branch_taken, ex_stall,
    input  fifo_empty,
    output stall_id, stall_rf, clear_rf,
    output fiforeaden, nw_timeout,
    output wait_cnt, drop_cnt
  );
endinterface

// File: rtl/rf_hazard_ctrl.sv
// RF-stage pipeline controller: load-use, flush,
// back-pressure and network FIFO read sequencing.
module rf_hazard_ctrl #(
  parameter int unsigned FIFO_TIMEOUT = 1024,
  parameter int unsigned CNTW         = 16
) (
  input logic             clk,
  input logic             reset,
  rf_hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FWAIT = 2'd1,
    FREAD = 2'd2
  } state_t;

  localparam logic [CNTW-1:0] MAXC = '1;
  localparam logic [CNTW-1:0] ONE  = CNTW'(1);
  localparam logic [CNTW-1:0] TMO  =
    CNTW'(FIFO_TIMEOUT);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CNTW-1:0] r_wait_cnt;
  logic [CNTW-1:0] r_drop_cnt;
  logic [CNTW-1:0] w_wait_nxt;
  logic [CNTW-1:0] w_drop_nxt;
  logic [CNTW-1:0] w_wait_inc;
  logic            r_nw_timeout;
  logic            w_tmo_nxt;
  logic            w_stall_id;
  logic            w_stall_rf;
  logic            w_clear_rf;
  logic            w_rden;
  logic            w_src_hit;
  logic            w_hazard;

  // Load-use match; r0 of the 32-bit set is exempt.
  always_comb begin
    w_src_hit =
      (bus.dec_use_rs1 && bus.dec_rs1 == bus.ex_rd) ||
      (bus.dec_use_rs2 && bus.dec_rs2 == bus.ex_rd);
    w_hazard = bus.dec_valid && bus.ex_load &&
      (bus.ex_rd != 5'd0 || bus.ex_flag512) &&
      (bus.dec_flag512 == bus.ex_flag512) &&
      w_src_hit;
    w_wait_inc = (r_wait_cnt == MAXC) ?
      MAXC : r_wait_cnt + ONE;
  end

  // Next state, counter updates and strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    w_drop_nxt  = r_drop_cnt;
    w_tmo_nxt   = r_nw_timeout;
    w_stall_id  = 1'b0;
    w_stall_rf  = 1'b0;
    w_clear_rf  = 1'b0;
    w_rden      = 1'b0;
    if (reset) begin
      w_clear_rf = 1'b1;
    end else if (bus.branch_taken) begin
      w_clear_rf  = 1'b1;
      w_state_nxt = RUN;
      w_wait_nxt  = '0;
      if (r_state == FREAD && r_drop_cnt != MAXC)
        w_drop_nxt = r_drop_cnt + ONE;
    end else if (bus.ex_stall) begin
      w_stall_id = 1'b1;
      w_stall_rf = 1'b1;
    end else begin
      unique case (r_state)
        RUN: begin
          if (bus.dec_valid && bus.dec_nwload) begin
            w_stall_id = 1'b1;
            w_clear_rf = 1'b1;
            if (bus.fifo_empty) begin
              w_state_nxt = FWAIT;
            end else begin
              w_rden      = 1'b1;
              w_state_nxt = FREAD;
            end
          end else if (w_hazard) begin
            w_stall_id = 1'b1;
            w_clear_rf = 1'b1;
          end
        end
        FWAIT: begin
          w_stall_id = 1'b1;
          w_clear_rf = 1'b1;
          w_wait_nxt = w_wait_inc;
          if (w_wait_inc >= TMO)
            w_tmo_nxt = 1'b1;
          if (!bus.fifo_empty) begin
            w_rden      = 1'b1;
            w_state_nxt = FREAD;
          end
        end
        FREAD: begin
          w_wait_nxt = '0;
          if (w_hazard) begin
            w_stall_id = 1'b1;
            w_clear_rf = 1'b1;
          end else begin
            w_state_nxt = RUN;
          end
        end
        default: begin
          w_state_nxt = RUN;
        end
      endcase
    end
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= RUN;
      r_wait_cnt   <= '0;
      r_drop_cnt   <= '0;
      r_nw_timeout <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_wait_cnt   <= w_wait_nxt;
      r_drop_cnt   <= w_drop_nxt;
      r_nw_timeout <= w_tmo_nxt;
    end
  end

  assign bus.stall_id   = w_stall_id;
  assign bus.stall_rf   = w_stall_rf;
  assign bus.clear_rf   = w_clear_rf;
  assign bus.fiforeaden = w_rden;
  assign bus.nw_timeout = r_nw_timeout;
  assign bus.wait_cnt   = r_wait_cnt;
  assign bus.drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_rf_hazard_ctrl.sv
// Scoreboard bench for rf_hazard_ctrl.
// Directed scenarios then biased random traffic.
module tb_rf_hazard_ctrl;
  localparam int CNTW = 16;
  localparam int TMO  = 4;
  localparam int MAXC = (1 << CNTW) - 1;

  logic clk;
  logic reset;

  rf_hazard_ctrl_if #(.CNTW(CNTW)) bus ();

  rf_hazard_ctrl #(
    .FIFO_TIMEOUT(TMO),
    .CNTW(CNTW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic       valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use1;
    logic       use2;
    logic       f512;
    logic       nwl;
    logic [4:0] rd;
    logic       ld;
    logic       xf512;
    logic       br;
    logic       xst;
    logic       emp;
  } in_t;

  typedef struct {
    logic sid;
    logic srf;
    logic clr;
    logic rden;
    logic tmo;
    int   wc;
    int   dc;
  } exp_t;

  exp_t exp_q[$];
  in_t  s;
  int   n_cmp;
  int   n_err;
  bit   mon_en;

  // Reference: is a FIFO entry popped and pending,
  // or is a network load waiting on an empty FIFO.
  bit   m_waiting;
  bit   m_holding;
  int   m_wait;
  int   m_drop;
  bit   m_tmo;

  task automatic chk(string nm, int act, int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d @%0t",
               nm, act, req, $time);
    end
  endtask

  function automatic bit hz(in_t i);
    bit hit;
    hit = (i.use1 && i.rs1 == i.rd) ||
          (i.use2 && i.rs2 == i.rd);
    return i.valid && i.ld && hit &&
           (i.rd != 0 || i.xf512) &&
           (i.f512 == i.xf512);
  endfunction

  task automatic model(in_t i);
    exp_t e;
    e = '{sid: 0, srf: 0, clr: 0, rden: 0,
          tmo: m_tmo, wc: m_wait, dc: m_drop};
    if (i.rst) begin
      e.clr = 1;
      m_waiting = 0;
      m_holding = 0;
      m_wait = 0;
      m_drop = 0;
      m_tmo = 0;
    end else if (i.br) begin
      e.clr = 1;
      if (m_holding) m_drop = (m_drop < MAXC) ?
        m_drop + 1 : MAXC;
      m_waiting = 0;
      m_holding = 0;
      m_wait = 0;
    end else if (i.xst) begin
      e.sid = 1;
      e.srf = 1;
    end else if (m_holding) begin
      m_wait = 0;
      if (hz(i)) begin
        e.sid = 1;
        e.clr = 1;
      end else begin
        m_holding = 0;
      end
    end else if (m_waiting) begin
      e.sid = 1;
      e.clr = 1;
      m_wait = (m_wait < MAXC) ? m_wait + 1 : MAXC;
      if (m_wait >= TMO) m_tmo = 1;
      if (!i.emp) begin
        e.rden = 1;
        m_waiting = 0;
        m_holding = 1;
      end
    end else if (i.valid && i.nwl) begin
      e.sid = 1;
      e.clr = 1;
      if (i.emp) m_waiting = 1;
      else begin
        e.rden = 1;
        m_holding = 1;
      end
    end else if (hz(i)) begin
      e.sid = 1;
      e.clr = 1;
    end
    exp_q.push_back(e);
  endtask

  task automatic drive(in_t i);
    reset            = i.rst;
    bus.dec_valid    = i.valid;
    bus.dec_rs1      = i.rs1;
    bus.dec_rs2      = i.rs2;
    bus.dec_use_rs1  = i.use1;
    bus.dec_use_rs2  = i.use2;
    bus.dec_flag512  = i.f512;
    bus.dec_nwload   = i.nwl;
    bus.ex_rd        = i.rd;
    bus.ex_load      = i.ld;
    bus.ex_flag512   = i.xf512;
    bus.branch_taken = i.br;
    bus.ex_stall     = i.xst;
    bus.fifo_empty   = i.emp;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive(s);
    model(s);
    mon_en = 1'b1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  // Monitor: compares every cycle against the queue.
  initial begin
    exp_t e;
    bit prev_rd;
    prev_rd = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("stall_id", int'(bus.stall_id), int'(e.sid));
        chk("stall_rf", int'(bus.stall_rf), int'(e.srf));
        chk("clear_rf", int'(bus.clear_rf), int'(e.clr));
        chk("fiforeaden", int'(bus.fiforeaden),
            int'(e.rden));
        chk("nw_timeout", int'(bus.nw_timeout),
            int'(e.tmo));
        chk("wait_cnt", int'(bus.wait_cnt), e.wc);
        chk("drop_cnt", int'(bus.drop_cnt), e.dc);
        chk("rden_b2b",
            int'(prev_rd && bus.fiforeaden), 0);
        chk("rden_blocked", int'(bus.fiforeaden &&
            (bus.ex_stall || bus.branch_taken)), 0);
        prev_rd = bus.fiforeaden;
      end else if (mon_en) begin
        chk("scoreboard_empty", 0, 1);
      end
    end
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    mon_en = 0;
    m_waiting = 0;
    m_holding = 0;
    m_wait = 0;
    m_drop = 0;
    m_tmo = 0;
    s = '0;
    s.emp = 1;
    s.rst = 1;
    drive(s);

    // Reset held two cycles
    step();
    step();
    at_neg();
    chk("rst_clear", int'(bus.clear_rf), 1);
    chk("rst_sid", int'(bus.stall_id), 0);
    chk("rst_wc", int'(bus.wait_cnt), 0);
    s.rst = 0;
    step();

    // Load-use on rs2 == rd == 5
    s.valid = 1;
    s.use2 = 1;
    s.rs2 = 5;
    s.rd = 5;
    s.ld = 1;
    step();
    at_neg();
    chk("lu_sid", int'(bus.stall_id), 1);
    chk("lu_clr", int'(bus.clear_rf), 1);
    s.ld = 0;
    step();
    at_neg();
    chk("lu_after", int'(bus.stall_id), 0);
    s.ld = 1;
    s.rd = 0;
    s.rs2 = 0;
    step();
    at_neg();
    chk("lu_r0", int'(bus.stall_id), 0);
    s.f512 = 1;
    s.xf512 = 1;
    step();
    at_neg();
    chk("lu_v0", int'(bus.stall_id), 1);
    s = '0;
    s.emp = 1;
    step();

    // FIFO ready
    s.valid = 1;
    s.nwl = 1;
    s.emp = 0;
    step();
    at_neg();
    chk("rdy_pop", int'(bus.fiforeaden), 1);
    chk("rdy_clr", int'(bus.clear_rf), 1);
    s.valid = 0;
    s.nwl = 0;
    step();
    at_neg();
    chk("rdy_idle_pop", int'(bus.fiforeaden), 0);
    chk("rdy_idle_clr", int'(bus.clear_rf), 0);

    // FIFO wait: empty for 5 cycles, timeout 4
    s.valid = 1;
    s.nwl = 1;
    s.emp = 1;
    for (int k = 0; k < 5; k++) step();
    s.emp = 0;
    step();
    at_neg();
    chk("wt_pop", int'(bus.fiforeaden), 1);
    s.valid = 0;
    s.nwl = 0;
    step();
    at_neg();
    chk("wt_cnt", int'(bus.wait_cnt), 5);
    chk("wt_tmo", int'(bus.nw_timeout), 1);
    step();
    at_neg();
    chk("wt_tmo_sticky", int'(bus.nw_timeout), 1);

    // Flush in FREAD loses the popped entry
    s.valid = 1;
    s.nwl = 1;
    step();
    s.valid = 0;
    s.nwl = 0;
    s.br = 1;
    step();
    at_neg();
    chk("fl_clr", int'(bus.clear_rf), 1);
    s.br = 0;
    step();
    at_neg();
    chk("fl_drop", int'(bus.drop_cnt), 1);

    // Flush during FWAIT: no pop, no drop
    s.valid = 1;
    s.nwl = 1;
    s.emp = 1;
    step();
    step();
    s.br = 1;
    step();
    at_neg();
    chk("fw_pop", int'(bus.fiforeaden), 0);
    s = '0;
    step();
    at_neg();
    chk("fw_drop", int'(bus.drop_cnt), 1);

    // Back-pressure during FWAIT
    s.valid = 1;
    s.nwl = 1;
    s.emp = 1;
    step();
    step();
    s.emp = 0;
    s.xst = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      at_neg();
      chk("bp_pop", int'(bus.fiforeaden), 0);
      chk("bp_srf", int'(bus.stall_rf), 1);
      chk("bp_wc", int'(bus.wait_cnt), 1);
    end
    s.xst = 0;
    step();
    at_neg();
    chk("bp_pop_after", int'(bus.fiforeaden), 1);
    s = '0;
    step();

    // Biased random traffic
    for (int k = 0; k < 3000; k++) begin
      s.rst   = ($urandom_range(0, 79) == 0);
      s.valid = ($urandom_range(0, 3) != 0);
      s.rs1   = 5'($urandom_range(0, 3));
      s.rs2   = 5'($urandom_range(0, 3));
      s.use1  = $urandom_range(0, 1) == 1;
      s.use2  = $urandom_range(0, 1) == 1;
      s.f512  = ($urandom_range(0, 3) == 0);
      s.nwl   = ($urandom_range(0, 3) == 0);
      s.rd    = 5'($urandom_range(0, 3));
      s.ld    = $urandom_range(0, 1) == 1;
      s.xf512 = ($urandom_range(0, 3) == 0);
      s.br    = ($urandom_range(0, 15) == 0);
      s.xst   = ($urandom_range(0, 5) == 0);
      s.emp   = $urandom_range(0, 1) == 1;
      step();
    end

    at_neg();
    mon_en = 0;
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
